// File: rtl/noc_pkg.sv
// Shared definitions for the NoC local-inject arbiter.
//   arb_state_t   : arbiter FSM states (IDLE / FWD / DROP)
//   DEST_ROW_*    : header bit-field holding the destination mesh row
//   DEST_COL_*    : header bit-field holding the destination mesh column
//   CNT_W         : width of the optional statistics counters
//   idx_w()       : index width for an N-entry requester vector (min 1)
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } arb_state_t;

  localparam int DEST_ROW_MSB = 15;
  localparam int DEST_ROW_LSB = 8;
  localparam int DEST_COL_MSB = 7;
  localparam int DEST_COL_LSB = 0;

  localparam int CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority requester index
//   grant : one-hot grant, first set req bit at or after ptr (wrapping)
//   idx   : binary index of the granted requester (0 when none)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IW'((32'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-locked round-robin arbiter feeding a router local inject port.
// Each packet takes one IDLE arbitration cycle; the winner's header is
// range-checked against the mesh and the packet is then forwarded through
// a one-flit output register (FWD) or silently discarded (DROP).
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req_flit_i    : N_REQ flattened requester flits
//   req_valid_i   : requester flit valid
//   req_last_i    : requester flit is packet tail
//   req_ready_o   : requester flit accepted on valid&ready
//   inj_flit_o    : flit to router local input
//   inj_valid_o   : flit valid to router
//   inj_ready_i   : router local input ready
//   drop_pulse_o  : one-cycle pulse after a dropped packet's tail
//   busy_o        : FSM not IDLE or output register full
// Optional (macro NOC_INJ_ARB_STATS_EN):
//   grant_cnt_o   : per-requester wrapping count of forwarded packets
//   drop_cnt_o    : saturating count of dropped packets
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int FLIT_W = 64,
  parameter int ROWS   = 2,
  parameter int COLS   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*FLIT_W-1:0] req_flit_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [FLIT_W-1:0]       inj_flit_o,
  output logic                    inj_valid_o,
  input  logic                    inj_ready_i,
  output logic                    drop_pulse_o,
  output logic                    busy_o
`ifdef NOC_INJ_ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]  grant_cnt_o,
  output logic [CNT_W-1:0]        drop_cnt_o
`endif
);

  localparam int IW = idx_w(N_REQ);

  arb_state_t state_q, state_d;

  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     owner_q;
  logic [IW-1:0]     ptr_next;
  logic [N_REQ-1:0]  pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [FLIT_W-1:0] pick_flit;
  logic [7:0]        hdr_row;
  logic [7:0]        hdr_col;
  logic              dest_ok;

  logic [FLIT_W-1:0] owner_flit;
  logic              owner_valid;
  logic              owner_last;
  logic              owner_ready;
  logic              accept;
  logic              tail;

  logic [FLIT_W-1:0] out_flit_q;
  logic              out_valid_q;
  logic              drop_pulse_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign pick_any  = |pick_grant;
  assign pick_flit = req_flit_i[pick_idx*FLIT_W +: FLIT_W];
  assign hdr_row   = pick_flit[DEST_ROW_MSB:DEST_ROW_LSB];
  assign hdr_col   = pick_flit[DEST_COL_MSB:DEST_COL_LSB];
  assign dest_ok   = (32'(hdr_row) < ROWS) && (32'(hdr_col) < COLS);

  assign owner_flit  = req_flit_i[owner_q*FLIT_W +: FLIT_W];
  assign owner_valid = req_valid_i[owner_q];
  assign owner_last  = req_last_i[owner_q];
  assign accept      = owner_ready && owner_valid;
  assign tail        = accept && owner_last;
  assign ptr_next    = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

  // Ready is masked during rst so nothing is handshaken in a cycle whose
  // effects the reset is about to discard.
  always_comb begin
    owner_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FWD:     owner_ready = !out_valid_q || inj_ready_i;
        DROP:    owner_ready = 1'b1;
        default: owner_ready = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = dest_ok ? FWD : DROP;
      FWD:     if (tail) state_d = IDLE;
      DROP:    if (tail) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready_o = '0;
    if (owner_ready) req_ready_o[owner_q] = 1'b1;
    busy_o = (state_q != IDLE) || out_valid_q;
  end

  assign inj_flit_o   = out_flit_q;
  assign inj_valid_o  = out_valid_q;
  assign drop_pulse_o = drop_pulse_q;

  // Owner, round-robin pointer and one-flit output register
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      out_flit_q   <= '0;
      out_valid_q  <= 1'b0;
      drop_pulse_q <= 1'b0;
    end else begin
      if (state_q == IDLE && pick_any) owner_q <= pick_idx;
      if (tail) rr_ptr_q <= ptr_next;
      // Load wins over drain: a same-cycle drain+load just replaces the flit.
      if (state_q == FWD && accept) begin
        out_flit_q  <= owner_flit;
        out_valid_q <= 1'b1;
      end else if (inj_ready_i) begin
        out_valid_q <= 1'b0;
      end
      drop_pulse_q <= (state_q == DROP) && tail;
    end
  end

`ifdef NOC_INJ_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt_q [N_REQ];
  logic [CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) grant_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (state_q == FWD && tail)
        grant_cnt_q[owner_q] <= grant_cnt_q[owner_q] + CNT_W'(1);
      if (state_q == DROP && tail && drop_cnt_q != '1)
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      grant_cnt_o[i*CNT_W +: CNT_W] = grant_cnt_q[i];
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
module tb_noc_inject_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] req_flit;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   inj_flit;
  logic           inj_valid;
  logic           inj_ready;
  logic           drop_pulse;
  logic           busy;
`ifdef NOC_INJ_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     drop_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  noc_inject_arbiter #(
    .N_REQ  (N),
    .FLIT_W (W),
    .ROWS   (2),
    .COLS   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_flit_i   (req_flit),
    .req_valid_i  (req_valid),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .inj_flit_o   (inj_flit),
    .inj_valid_o  (inj_valid),
    .inj_ready_i  (inj_ready),
    .drop_pulse_o (drop_pulse),
    .busy_o       (busy)
`ifdef NOC_INJ_ARB_STATS_EN
    ,
    .grant_cnt_o  (grant_cnt),
    .drop_cnt_o   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int r, input int s, input int row, input int col);
    return {8'(r), 8'(s), 32'hA5A5_5A5A, 8'(row), 8'(col)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic l, input logic [63:0] f);
    req_flit[r*W +: W] = f;
    req_valid[r]       = v;
    req_last[r]        = l;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_flit  = '0;
    req_valid = '0;
    req_last  = '0;
    inj_ready = 1'b1;

    // Reset state
    repeat (2) nxt();
    #1;
    chk("rst_inj_valid", 64'(inj_valid), 64'd0);
    chk("rst_inj_flit", inj_flit, 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    nxt();
    rst = 1'b0;

    // Fairness: four single-flit packets to (1,1)
    nxt();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b1, mk(k, 0, 1, 1));
    #1;
    chk("fair_idle_ready", 64'(req_ready), 64'd0);
    for (int k = 0; k < N; k++) begin
      nxt(); #1;
      chk("fair_grant", 64'(req_ready), 64'(1 << k));
      chk("fair_no_out", 64'(inj_valid), 64'd0);
      nxt();
      set_req(k, 1'b0, 1'b0, 64'd0);
      #1;
      chk("fair_out_valid", 64'(inj_valid), 64'd1);
      chk("fair_out_flit", inj_flit, mk(k, 0, 1, 1));
      chk("fair_arb_ready", 64'(req_ready), 64'd0);
    end
    chk("fair_busy_drain", 64'(busy), 64'd1);
    nxt(); #1;
    chk("fair_drained", 64'(inj_valid), 64'd0);
    chk("fair_idle_busy", 64'(busy), 64'd0);

    // Lock: req1 3-flit packet while req2 waits; rr_ptr moves to 2
    nxt();
    set_req(1, 1'b1, 1'b0, mk(1, 0, 1, 0));
    set_req(2, 1'b1, 1'b1, mk(2, 0, 0, 1));
    #1;
    chk("lock_idle", 64'(req_ready), 64'd0);
    nxt(); #1;
    chk("lock_g1", 64'(req_ready), 64'b0010);
    nxt();
    set_req(1, 1'b1, 1'b0, mk(1, 1, 1, 0));
    #1;
    chk("lock_f0", inj_flit, mk(1, 0, 1, 0));
    chk("lock_f0_v", 64'(inj_valid), 64'd1);
    chk("lock_r1", 64'(req_ready), 64'b0010);
    nxt();
    set_req(1, 1'b1, 1'b1, mk(1, 2, 1, 0));
    #1;
    chk("lock_f1", inj_flit, mk(1, 1, 1, 0));
    chk("lock_r2", 64'(req_ready), 64'b0010);
    nxt();
    set_req(1, 1'b0, 1'b0, 64'd0);
    set_req(0, 1'b1, 1'b1, mk(0, 0, 1, 0));
    #1;
    chk("lock_f2", inj_flit, mk(1, 2, 1, 0));
    chk("lock_tail_idle", 64'(req_ready), 64'd0);
    nxt(); #1;
    chk("lock_ptr2", 64'(req_ready), 64'b0100);
    chk("lock_gap", 64'(inj_valid), 64'd0);
    nxt();
    set_req(2, 1'b0, 1'b0, 64'd0);
    #1;
    chk("lock_req2_flit", inj_flit, mk(2, 0, 0, 1));
    nxt(); #1;
    chk("lock_wrap0", 64'(req_ready), 64'b0001);
    nxt();
    set_req(0, 1'b0, 1'b0, 64'd0);
    #1;
    chk("lock_req0_flit", inj_flit, mk(0, 0, 1, 0));

    // Backpressure: 5 stalled cycles mid-packet (rr_ptr=1)
    nxt();
    set_req(1, 1'b1, 1'b0, mk(1, 16, 0, 0));
    #1;
    chk("bp_idle", 64'(req_ready), 64'd0);
    nxt(); #1;
    chk("bp_grant", 64'(req_ready), 64'b0010);
    nxt();
    inj_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, mk(1, 17, 0, 0));
    for (int c = 0; c < 5; c++) begin
      if (c > 0) nxt();
      #1;
      chk("bp_hold_flit", inj_flit, mk(1, 16, 0, 0));
      chk("bp_hold_valid", 64'(inj_valid), 64'd1);
      chk("bp_hold_ready", 64'(req_ready), 64'd0);
    end
    nxt();
    inj_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'b0010);
    chk("bp_release_flit", inj_flit, mk(1, 16, 0, 0));
    nxt();
    set_req(1, 1'b1, 1'b1, mk(1, 18, 0, 0));
    #1;
    chk("bp_f1", inj_flit, mk(1, 17, 0, 0));
    chk("bp_f1_v", 64'(inj_valid), 64'd1);
    nxt();
    set_req(1, 1'b0, 1'b0, 64'd0);
    #1;
    chk("bp_f2", inj_flit, mk(1, 18, 0, 0));
    chk("bp_tail_ready", 64'(req_ready), 64'd0);
    nxt(); #1;
    chk("bp_no_dup", 64'(inj_valid), 64'd0);

    // Bad destination: 2-flit packet to (2,0) from req2 (rr_ptr=2)
    nxt();
    set_req(2, 1'b1, 1'b0, mk(2, 32, 2, 0));
    #1;
    chk("bad_idle", 64'(req_ready), 64'd0);
    nxt(); #1;
    chk("bad_ready_h", 64'(req_ready), 64'b0100);
    chk("bad_no_out_h", 64'(inj_valid), 64'd0);
    chk("bad_busy", 64'(busy), 64'd1);
    nxt();
    set_req(2, 1'b1, 1'b1, mk(2, 33, 0, 0));
    #1;
    chk("bad_ready_t", 64'(req_ready), 64'b0100);
    chk("bad_pulse_early", 64'(drop_pulse), 64'd0);
    nxt();
    set_req(2, 1'b0, 1'b0, 64'd0);
    #1;
    chk("bad_pulse", 64'(drop_pulse), 64'd1);
    chk("bad_no_out_t", 64'(inj_valid), 64'd0);
    chk("bad_tail_ready", 64'(req_ready), 64'd0);
`ifdef NOC_INJ_ARB_STATS_EN
    chk("bad_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("bad_grant_cnt", 64'(grant_cnt), {16'd1, 16'd2, 16'd3, 16'd2});
`endif
    nxt(); #1;
    chk("bad_pulse_end", 64'(drop_pulse), 64'd0);
    chk("bad_idle_busy", 64'(busy), 64'd0);

    // Reset mid-packet: req3 (rr_ptr=3) 3-flit packet, rst after flit 1
    nxt();
    set_req(3, 1'b1, 1'b0, mk(3, 48, 0, 0));
    #1;
    chk("rm_idle", 64'(req_ready), 64'd0);
    nxt(); #1;
    chk("rm_grant", 64'(req_ready), 64'b1000);
    nxt();
    set_req(3, 1'b1, 1'b0, mk(3, 49, 0, 0));
    rst = 1'b1;
    #1;
    chk("rm_f0", inj_flit, mk(3, 48, 0, 0));
    chk("rm_ready_in_rst", 64'(req_ready), 64'd0);
    nxt();
    rst = 1'b0;
    set_req(3, 1'b0, 1'b0, 64'd0);
    #1;
    chk("rm_inj_valid", 64'(inj_valid), 64'd0);
    chk("rm_inj_flit", inj_flit, 64'd0);
    chk("rm_req_ready", 64'(req_ready), 64'd0);
    chk("rm_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
`ifdef NOC_INJ_ARB_STATS_EN
    chk("rm_grant_cnt", 64'(grant_cnt), 64'd0);
    chk("rm_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    nxt();
    set_req(0, 1'b1, 1'b1, mk(0, 64, 0, 1));
    set_req(3, 1'b1, 1'b1, mk(3, 65, 1, 1));
    #1;
    chk("rm_post_idle", 64'(req_ready), 64'd0);
    chk("rm_post_no_out", 64'(inj_valid), 64'd0);
    nxt(); #1;
    chk("rm_ptr0", 64'(req_ready), 64'b0001);
    nxt();
    set_req(0, 1'b0, 1'b0, 64'd0);
    #1;
    chk("rm_req0_flit", inj_flit, mk(0, 64, 0, 1));
    nxt(); #1;
    chk("rm_next_req3", 64'(req_ready), 64'b1000);
    nxt();
    set_req(3, 1'b0, 1'b0, 64'd0);
    #1;
    chk("rm_req3_flit", inj_flit, mk(3, 65, 1, 1));

    // Single-flit burst from req3 alone
    for (int k = 0; k < 4; k++) begin
      nxt();
      set_req(3, 1'b1, 1'b1, mk(3, 80 + k, 1, 1));
      #1;
      chk("burst_idle", 64'(req_ready), 64'd0);
      if (k > 0) begin
        chk("burst_out_v", 64'(inj_valid), 64'd1);
        chk("burst_out_flit", inj_flit, mk(3, 80 + k - 1, 1, 1));
      end else begin
        chk("burst_start_empty", 64'(inj_valid), 64'd0);
      end
      nxt(); #1;
      chk("burst_grant", 64'(req_ready), 64'b1000);
      chk("burst_gap", 64'(inj_valid), 64'd0);
    end
    nxt();
    set_req(3, 1'b0, 1'b0, 64'd0);
    #1;
    chk("burst_last_v", 64'(inj_valid), 64'd1);
    chk("burst_last_flit", inj_flit, mk(3, 83, 1, 1));
    nxt(); #1;
    chk("burst_end_v", 64'(inj_valid), 64'd0);
    chk("burst_end_busy", 64'(busy), 64'd0);
`ifdef NOC_INJ_ARB_STATS_EN
    chk("burst_grant_cnt", 64'(grant_cnt), {16'd5, 16'd0, 16'd0, 16'd1});
    chk("burst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
